serial_bit_streamer: RTL
========================

Name: serial_bit_streamer

Overview:
Parallel-to-serial source stage that feeds the serial sequence-detector FSM. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on bit_out, MSB-first or LSB-first. It inserts a configurable idle gap between words and counts completed words. bit_out is registered on the rising edge, so it is stable at the falling-edge sample point of the downstream detector.

Parameters:
WIDTH, 8, word width in bits (legal range 2..32).
GAP, 0, number of idle-bit cycles inserted after each word (legal range 0..255).
IDLE_BIT, 1'b1, level driven on bit_out when no word bit is being sent.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous active-low reset.
din  input  WIDTH  parallel word to serialize.
din_valid  input  1  din holds a word to send.
din_ready  output  1  block accepts din this cycle.
lsb_first  input  1  bit order, sampled at word acceptance (1 = LSB first).
flush  input  1  synchronous abort of the current word/gap.
bit_out  output  1  serial data to the downstream detector input.
bit_valid  output  1  bit_out carries a word bit this cycle.
busy  output  1  state is not IDLE.
word_done  output  1  one-cycle pulse while the last bit of a word is on bit_out.
words_sent  output  16  completed-word counter.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous, active-low.
- Reset values, applied immediately on reset low:
  - state = IDLE, shift register = 0, bit counter = 0, gap counter = 0.
  - bit_out = IDLE_BIT, bit_valid = 0, busy = 0, word_done = 0, words_sent = 0.
  - din_ready is forced 0 while reset is low.
- States: IDLE, SHIFT, GAP.
- Accept: a word is taken at the rising edge where din_valid && din_ready. At that edge, din and lsb_first are latched.
- din_ready is combinational and equals 1 when !flush and any of the following holds:
  - state is IDLE;
  - state is SHIFT, on the last bit, with GAP == 0;
  - state is GAP, on its final gap cycle.
- Latency: the first bit appears on bit_out in the cycle immediately after the accept edge.
- SHIFT: one bit per cycle for exactly WIDTH cycles, bit_valid = 1. Order is MSB-first when latched lsb_first = 0, else LSB-first. din changes after acceptance are ignored.
- Last bit (bit counter == WIDTH-1):
  - word_done = 1 that cycle; words_sent increments at the closing edge, wrapping 16'hFFFF -> 0.
  - If GAP == 0: on accept, load the new word and stay in SHIFT (back-to-back, no bubble); otherwise go to IDLE.
  - If GAP > 0: go to GAP.
- GAP: lasts exactly GAP cycles with bit_out = IDLE_BIT and bit_valid = 0.
  - An accept in the final GAP cycle goes to SHIFT; otherwise go to IDLE.
  - Net result: exactly GAP idle cycles between words under continuous supply.
- IDLE: bit_out = IDLE_BIT, bit_valid = 0, busy = 0.
- flush (highest priority below reset):
  - At the next edge: state goes to IDLE and all counters clear except words_sent; bit_out = IDLE_BIT and bit_valid = 0 from the next cycle.
  - The partial word is discarded: no word_done, no words_sent increment.
  - flush coinciding with the last bit still suppresses word_done counting; word_done is gated by !flush.
  - No accept happens in a flush cycle.
- Outputs bit_out, bit_valid and busy are registered (glitch-free). word_done and din_ready are combinational from registered state and inputs.
- din_valid dropping mid-word has no effect on the word in progress.

Test Plan:
1. WIDTH=8, GAP=0, lsb_first=0, din=8'hC1 accepted once -> bit_out = 1,1,0,0,0,0,0,1 on 8 consecutive cycles from the cycle after accept; bit_valid high exactly 8 cycles; word_done on 8th; words_sent=1; then bit_out=1, busy=0.
2. Same with lsb_first=1 -> bit_out = 1,0,0,0,0,0,1,1; lsb_first toggled mid-word has no effect.
3. GAP=0, din_valid held with 8'hC1 then 8'h3C -> 16 contiguous valid bits 11000001 00111100; din_ready high only in IDLE accept cycle and on bit 8; words_sent=2.
4. GAP=3, two queued words -> exactly 3 cycles of bit_valid=0, bit_out=1 between word 1 bit 8 and word 2 bit 1.
5. flush asserted during bit 4 of 8'hC1 -> next cycle bit_out=1, bit_valid=0, busy=0; no word_done; words_sent unchanged; din_ready=0 during flush cycle.
6. reset driven low mid-word (between edges) after 5 words sent -> outputs take reset values immediately without a clock edge; words_sent=0; first word after release serializes normally.

Source files
------------

// File: rtl/serial_bit_streamer.sv
// serial_bit_streamer
// Parallel-to-serial source stage for the serial sequence detector. Words
// arrive on a valid/ready handshake. They leave one bit per clock on bit_out,
// MSB-first or LSB-first. An optional idle gap follows each word, and the
// block counts completed words.
//
// Ports:
//   clk         system clock, rising-edge active
//   reset       asynchronous active-low reset
//   din         parallel word to serialize (WIDTH bits)
//   din_valid   din holds a word to send
//   din_ready   block accepts din this cycle (combinational)
//   lsb_first   bit order, latched at word acceptance (1 = LSB first)
//   flush       synchronous abort of the current word/gap
//   bit_out     serial data (registered)
//   bit_valid   bit_out carries a word bit (registered)
//   busy        block is not idle (registered)
//   word_done   pulse while the last bit of a word is on bit_out
//   words_sent  completed-word counter, wraps at 16 bits
module serial_bit_streamer #(
  parameter int   WIDTH    = 8,
  parameter int   GAP      = 0,
  parameter logic IDLE_BIT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             lsb_first,
  input  logic             flush,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             word_done,
  output logic [15:0]      words_sent
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [7:0] GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
  localparam logic GAP_NONE = (GAP == 0);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             lsb_q, lsb_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             busy_q, busy_d;
  logic [15:0]      words_q, words_d;

  logic             last_bit_s;
  logic             gap_last_s;
  logic             accept_s;
  logic             first_bit_s;
  logic             next_bit_s;
  logic [WIDTH-1:0] shifted_s;

  // Handshake and word-boundary decode from registered state
  always_comb begin
    last_bit_s = (state_q == ST_SHIFT) && (bit_cnt_q == LAST_BIT);
    gap_last_s = (state_q == ST_GAP) && (gap_cnt_q == GAP_LAST);
    // Ready is held low during reset even though the state is already IDLE.
    din_ready  = reset && !flush &&
                 ((state_q == ST_IDLE) || (last_bit_s && GAP_NONE) || gap_last_s);
    accept_s   = din_valid && din_ready;
    word_done  = last_bit_s && !flush;
  end

  // Bit selection: the bit currently on the wire sits at the shift-out end
  // of shreg_q, so the next one is its neighbour.
  always_comb begin
    first_bit_s = lsb_first ? din[0] : din[WIDTH-1];
    if (lsb_q) begin
      next_bit_s = shreg_q[1];
      shifted_s  = {1'b0, shreg_q[WIDTH-1:1]};
    end else begin
      next_bit_s = shreg_q[WIDTH-2];
      shifted_s  = {shreg_q[WIDTH-2:0], 1'b0};
    end
  end

  // Next-state logic: flush beats accept, accept beats normal sequencing
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    lsb_d       = lsb_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = bit_valid_q;
    if (flush) begin
      state_d     = ST_IDLE;
      shreg_d     = '0;
      bit_cnt_d   = '0;
      gap_cnt_d   = 8'd0;
      bit_out_d   = IDLE_BIT;
      bit_valid_d = 1'b0;
    end else if (accept_s) begin
      // The first bit is registered straight from din so it appears next cycle.
      state_d     = ST_SHIFT;
      shreg_d     = din;
      lsb_d       = lsb_first;
      bit_cnt_d   = '0;
      gap_cnt_d   = 8'd0;
      bit_out_d   = first_bit_s;
      bit_valid_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          bit_out_d   = IDLE_BIT;
          bit_valid_d = 1'b0;
        end
        ST_SHIFT: begin
          if (last_bit_s) begin
            state_d     = GAP_NONE ? ST_IDLE : ST_GAP;
            bit_cnt_d   = '0;
            gap_cnt_d   = 8'd0;
            bit_out_d   = IDLE_BIT;
            bit_valid_d = 1'b0;
          end else begin
            bit_cnt_d   = bit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            shreg_d     = shifted_s;
            bit_out_d   = next_bit_s;
            bit_valid_d = 1'b1;
          end
        end
        ST_GAP: begin
          bit_out_d   = IDLE_BIT;
          bit_valid_d = 1'b0;
          if (gap_last_s) begin
            state_d   = ST_IDLE;
            gap_cnt_d = 8'd0;
          end else begin
            gap_cnt_d = gap_cnt_q + 8'd1;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          bit_cnt_d   = '0;
          gap_cnt_d   = 8'd0;
          bit_out_d   = IDLE_BIT;
          bit_valid_d = 1'b0;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // Completed-word counter; word_done already excludes flushed words
  always_comb begin
    if (word_done) begin
      words_d = words_q + 16'd1;
    end else begin
      words_d = words_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      lsb_q       <= 1'b0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= 8'd0;
      bit_out_q   <= IDLE_BIT;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      words_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      lsb_q       <= lsb_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      busy_q      <= busy_d;
      words_q     <= words_d;
    end
  end

  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign busy       = busy_q;
  assign words_sent = words_q;

endmodule
